// File: rtl/row_demux.sv
// Serial-to-parallel demultiplexer: steers a stream of operand words into
// LANES lane registers and presents each completed vector with valid/ready.
module row_demux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*WIDTH-1:0]         out_data,
  output logic [$clog2(LANES+1)-1:0]     out_count,
  output logic                           out_last
);

  localparam int unsigned IW = $clog2(LANES);
  localparam int unsigned CW = $clog2(LANES+1);
  localparam logic [IW-1:0] LAST_LANE = IW'(LANES - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] lanes_q [LANES];
  logic [WIDTH-1:0] lanes_d [LANES];
  logic [CW-1:0]    count_d;
  logic             last_d;

  // Upstream may push whenever a vector is filling or the held vector drains.
  assign in_ready  = (state_q == FILL) || out_ready;
  assign out_valid = (state_q == FULL);

  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      out_data[i*WIDTH +: WIDTH] = lanes_q[i];
    end
  end

  // Next-state, lane steering, zero-fill and vector metadata.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = out_count;
    last_d  = out_last;
    for (int i = 0; i < int'(LANES); i++) begin
      lanes_d[i] = lanes_q[i];
    end

    case (state_q)
      FILL: begin
        if (in_valid) begin
          lanes_d[cnt_q] = in_data;
          if (cnt_q == LAST_LANE || in_last) begin
            for (int i = 0; i < int'(LANES); i++) begin
              if (IW'(i) > cnt_q) lanes_d[i] = '0;
            end
            count_d = CW'(cnt_q) + CW'(1);
            last_d  = in_last;
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          if (in_valid) begin
            // Hand-off cycle: the new word starts the next vector in lane 0.
            lanes_d[0] = in_data;
            for (int i = 1; i < int'(LANES); i++) begin
              lanes_d[i] = '0;
            end
            cnt_d = IW'(1);
            if (in_last) begin
              count_d = CW'(1);
              last_d  = 1'b1;
              state_d = FULL;
            end else begin
              state_d = FILL;
            end
          end else begin
            cnt_d   = '0;
            state_d = FILL;
          end
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
        lanes_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_count <= count_d;
      out_last  <= last_d;
      for (int i = 0; i < int'(LANES); i++) begin
        lanes_q[i] <= lanes_d[i];
      end
    end
  end

endmodule

// File: tb/tb_row_demux.sv
// Directed bench for row_demux (WIDTH=8, LANES=4) with hand-computed vectors.
module tb_row_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  row_demux #(.WIDTH(8), .LANES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_vec(input string tag, input logic [31:0] d, input logic [2:0] c, input logic l);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  out_data, d);
    check({tag, "_count"}, 32'(out_count), 32'(c));
    check({tag, "_last"},  32'(out_last), 32'(l));
  endtask

  logic [31:0] exp_vec;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  out_data, 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Full vector with out_ready held high
    out_ready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check("full_not_yet", 32'(out_valid), 32'd0);
    send(8'h44, 1'b0);
    check_vec("full", 32'h44332211, 3'd4, 1'b0);
    tick();
    check("full_drained", 32'(out_valid), 32'd0);

    // Short vector closed by in_last, then held under backpressure
    out_ready = 1'b0;
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    check_vec("short", 32'h0000A2A1, 3'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, 32'h0000A2A1);
      check("bp_count", 32'(out_count), 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_word_not_taken", out_data, 32'h0000A2A1);

    // Back-to-back: 12 words, 3 vectors, no idle input cycles
    for (int k = 1; k <= 12; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + k);
      in_last  = 1'b0;
      #1;
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      tick();
      if (k % 4 == 0) begin
        for (int j = 0; j < 4; j++) exp_vec[j*8 +: 8] = 8'(8'h10 + k - 3 + j);
        check_vec("b2b", exp_vec, 3'd4, 1'b0);
      end else begin
        check("b2b_idle_valid", 32'(out_valid), 32'd0);
      end
    end

    // Simultaneous hand-off with a last word: stays FULL with a 1-lane vector
    send(8'h5A, 1'b1);
    check_vec("simul_last", 32'h0000005A, 3'd1, 1'b1);
    out_ready = 1'b0;
    tick();
    check("simul_still_full", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("simul_drained", 32'(out_valid), 32'd0);

    // in_last on the final lane gives a full vector with out_last set
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    check_vec("full_last", 32'h04030201, 3'd4, 1'b1);
    tick();

    // Reset mid-fill clears outputs before any clock edge
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    check("mid_partial", out_data, 32'h04038877);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  out_data, 32'd0);
    check("mid_rst_count", 32'(out_count), 32'd0);
    check("mid_rst_last",  32'(out_last), 32'd0);
    tick();
    rst = 1'b0;
    send(8'h99, 1'b1);
    check_vec("post_rst", 32'h00000099, 3'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
